// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer between uart_rx and the CPU peripheral block.
// First-word fall-through FIFO with a sticky overflow flag, an idle
// timer and a registered level interrupt.
module uart_rx_fifo #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int THRESH  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf,
  input  logic              irq_en,
  output logic              irq
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(TIMEOUT);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   THRESH_C = (ADDR_W + 1)'(THRESH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              ovf_q, ovf_d;
  logic              irq_q, irq_d;
  logic              empty_w, full_w;
  logic              push, pop, drop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  // A pop frees a slot in the same cycle, so a full buffer still accepts a byte.
  assign pop  = rd_en && !empty_w;
  assign push = rx_valid && (!full_w || pop);
  assign drop = rx_valid && full_w && !pop;

  // Next-state logic for pointers, level, overflow, idle timer and interrupt.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    timer_d  = timer_q;
    ovf_d    = ovf_q;
    irq_d    = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;

    // Timer only runs while data sits untouched in the buffer.
    if (push || pop || empty_w) timer_d = '0;
    else if (timer_q != TMR_MAX) timer_d = timer_q + TMR_W'(1);

    // Interrupt follows the values count and timer take at this edge.
    irq_d = irq_en && ((count_d >= THRESH_C) || (timer_d == TMR_MAX));
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // Byte storage; cleared on reset so the head reads 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with immediate-assertion checks.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       clr_ovf;
  logic       irq_en;
  logic       irq;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(
    .DEPTH(16), .ADDR_W(4), .THRESH(8), .TIMEOUT(1024)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf),
    .irq_en(irq_en), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rd_en    = 1'b0;
    clr_ovf  = 1'b0;
    irq_en   = 1'b0;

    // Reset state
    #12;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    reset = 1'b1;
    tick();

    // 1: single byte through
    push(8'hA5);
    chk("t1_empty", 32'(empty), 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_rd_data", 32'(rd_data), 32'hA5);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t1_pop_empty", 32'(empty), 32'd1);
    chk("t1_pop_count", 32'(count), 32'd0);
    // pop while empty is ignored
    pop();
    chk("t1_underflow_count", 32'(count), 32'd0);

    // 2: fill, overflow, drain
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count", 32'(count), 32'd16);
    chk("t2_ovf_before", 32'(overflow), 32'd0);
    chk("t2_irq_disabled", 32'(irq), 32'd0);
    push(8'hFF);
    chk("t2_ovf_set", 32'(overflow), 32'd1);
    chk("t2_count_after_drop", 32'(count), 32'd16);
    chk("t2_irq_no_ovf_irq", 32'(irq), 32'd0);
    // drop and clear together: set wins
    clr_ovf = 1'b1;
    push(8'hEE);
    clr_ovf = 1'b0;
    chk("t2_set_wins", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t2_ovf_clear", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_pop%0d", i), 32'(rd_data), 32'(i));
      pop();
    end
    chk("t2_drained", 32'(empty), 32'd1);

    // 3: simultaneous push and pop while full
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    chk("t3_full", 32'(full), 32'd1);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    rd_en    = 1'b1;
    tick();
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_head", 32'(rd_data), 32'h11);
    for (int i = 0; i < 15; i++) pop();
    chk("t3_tail_byte", 32'(rd_data), 32'h55);
    chk("t3_tail_count", 32'(count), 32'd1);
    pop();
    chk("t3_empty", 32'(empty), 32'd1);

    // 3b: push and pop together while empty is push only
    rx_valid = 1'b1;
    rx_data  = 8'h3C;
    rd_en    = 1'b1;
    tick();
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    chk("t3b_count", 32'(count), 32'd1);
    chk("t3b_data", 32'(rd_data), 32'h3C);
    pop();

    // 4: threshold interrupt
    irq_en = 1'b1;
    for (int i = 0; i < 7; i++) push(8'(8'h20 + i));
    chk("t4_irq_7", 32'(irq), 32'd0);
    push(8'h27);
    chk("t4_irq_8", 32'(irq), 32'd1);
    pop();
    chk("t4_irq_after_pop", 32'(irq), 32'd0);
    for (int i = 0; i < 7; i++) pop();
    chk("t4_empty", 32'(empty), 32'd1);

    // 5: idle timeout interrupt
    push(8'h77);
    repeat (1023) tick();
    chk("t5_irq_early", 32'(irq), 32'd0);
    tick();
    chk("t5_irq_timeout", 32'(irq), 32'd1);
    tick();
    chk("t5_irq_held", 32'(irq), 32'd1);
    pop();
    chk("t5_irq_cleared", 32'(irq), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    chk("t6_count_before", 32'(count), 32'd8);
    chk("t6_irq_before", 32'(irq), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    chk("t6_rd_data", 32'(rd_data), 32'h00);
    reset = 1'b1;
    tick();
    push(8'h99);
    chk("t6_after_count", 32'(count), 32'd1);
    chk("t6_after_data", 32'(rd_data), 32'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
